// File: rtl/stopwatch_timer_core_pkg.sv
// Shared types and constants for the stopwatch timing core: state encoding,
// BCD digit bundle and the binary-to-BCD helper.
package stopwatch_timer_core_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StAdjust = 2'd2,
    StDone   = 2'd3
  } state_e;

  localparam int unsigned DigitW = 4;
  localparam int unsigned SecMax = 59;

  typedef struct packed {
    logic [DigitW-1:0] min_t;
    logic [DigitW-1:0] min_o;
    logic [DigitW-1:0] sec_t;
    logic [DigitW-1:0] sec_o;
  } digits_t;

  // Two BCD digits for a binary value 0..99.
  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

endpackage

// File: rtl/stopwatch_timer_core_if.sv
// Control inputs and display/status outputs of the stopwatch core.
// master drives the buttons/switches, slave is the core.
interface stopwatch_timer_core_if;
  logic       run_toggle;
  logic       adj_en;
  logic       adj_sel;
  logic       dir_down;
  logic       lap;
  logic [3:0] min_t;
  logic [3:0] min_o;
  logic [3:0] sec_t;
  logic [3:0] sec_o;
  logic       running;
  logic       done;
  logic       blank_sec;
  logic       blank_min;
  logic       lap_active;

  modport master (
    output run_toggle, adj_en, adj_sel, dir_down, lap,
    input  min_t, min_o, sec_t, sec_o, running, done, blank_sec, blank_min, lap_active
  );

  modport slave (
    input  run_toggle, adj_en, adj_sel, dir_down, lap,
    output min_t, min_o, sec_t, sec_o, running, done, blank_sec, blank_min, lap_active
  );
endinterface

// File: rtl/stopwatch_timer_core_prescaler.sv
// Divide-by-DIV prescaler: one-cycle tick at terminal count, synchronous clear
// holds the count at zero.
module stopwatch_timer_core_prescaler #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);
  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] Last = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = !clear && (cnt_q == Last);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/stopwatch_timer_core.sv
// mm:ss stopwatch core: up/down count, DONE at 00:00, field adjust with blink, BCD out.
// Optional lap freeze is built only when STOPWATCH_LAP_CAPTURE_EN is defined.
module stopwatch_timer_core
  import stopwatch_timer_core_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned TICK_HZ  = 1,
  parameter int unsigned ADJ_HZ   = 2,
  parameter int unsigned BLINK_HZ = 4,
  parameter int unsigned MAX_MIN  = 99
) (
  input logic                   clk,
  input logic                   btnR,
  stopwatch_timer_core_if.slave sw
);
  localparam logic [5:0] SecLast = 6'(SecMax);
  localparam logic [6:0] MinLast = 7'(MAX_MIN);

  state_e     state_q, state_d;
  logic [5:0] sec_q, sec_d;
  logic [6:0] min_q, min_d;
  logic       blink_q, blink_d;
  digits_t    live_q, live_d, shown;
  logic       in_run, in_adj, at_zero;
  logic       run_tick, adj_tick, blink_tick;

  assign in_run  = (state_q == StRun);
  assign in_adj  = (state_q == StAdjust);
  assign at_zero = (sec_q == '0) && (min_q == '0);

  stopwatch_timer_core_prescaler #(
    .DIV(CLK_HZ / TICK_HZ)
  ) u_run_pre (
    .clk  (clk),
    .rst  (btnR),
    .clear(!in_run),
    .tick (run_tick)
  );

  stopwatch_timer_core_prescaler #(
    .DIV(CLK_HZ / ADJ_HZ)
  ) u_adj_pre (
    .clk  (clk),
    .rst  (btnR),
    .clear(!in_adj),
    .tick (adj_tick)
  );

  stopwatch_timer_core_prescaler #(
    .DIV(CLK_HZ / (2 * BLINK_HZ))
  ) u_blink_pre (
    .clk  (clk),
    .rst  (btnR),
    .clear(!in_adj),
    .tick (blink_tick)
  );

  always_comb begin
    state_d = state_q;
    if (sw.adj_en) begin
      state_d = StAdjust;
    end else begin
      case (state_q)
        StIdle:   if (sw.run_toggle) state_d = StRun;
        StRun: begin
          if (sw.run_toggle) begin
            state_d = StIdle;
          end else if (run_tick && sw.dir_down && at_zero) begin
            state_d = StDone;
          end
        end
        StAdjust: state_d = StIdle;
        StDone:   if (sw.run_toggle) state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  // A run tick is applied even when the state leaves RUN in the same cycle.
  always_comb begin
    sec_d = sec_q;
    min_d = min_q;
    if (in_run && run_tick) begin
      if (!sw.dir_down) begin
        if (sec_q == SecLast) begin
          sec_d = '0;
          min_d = (min_q == MinLast) ? '0 : min_q + 7'd1;
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else if (!at_zero) begin
        if (sec_q == '0) begin
          sec_d = SecLast;
          min_d = min_q - 7'd1;
        end else begin
          sec_d = sec_q - 6'd1;
        end
      end
    end else if (in_adj && adj_tick) begin
      if (sw.adj_sel) begin
        min_d = (min_q == MinLast) ? '0 : min_q + 7'd1;
      end else begin
        sec_d = (sec_q == SecLast) ? '0 : sec_q + 6'd1;
      end
    end
  end

  assign blink_d = in_adj ? (blink_q ^ blink_tick) : 1'b0;
  assign live_d  = {to_bcd(min_q), to_bcd({1'b0, sec_q})};

  always_ff @(posedge clk) begin
    if (btnR) begin
      state_q <= StIdle;
      sec_q   <= '0;
      min_q   <= '0;
      blink_q <= 1'b0;
      live_q  <= '0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      blink_q <= blink_d;
      live_q  <= live_d;
    end
  end

`ifdef STOPWATCH_LAP_CAPTURE_EN
  digits_t lap_q, lap_d;
  logic    lap_act_q, lap_act_d;

  // Freeze only while staying in RUN; any exit from RUN drops the freeze.
  always_comb begin
    lap_d     = lap_q;
    lap_act_d = 1'b0;
    if (in_run && (state_d == StRun)) begin
      lap_act_d = lap_act_q;
      if (sw.lap) begin
        lap_act_d = !lap_act_q;
        if (!lap_act_q) begin
          lap_d = live_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (btnR) begin
      lap_q     <= '0;
      lap_act_q <= 1'b0;
    end else begin
      lap_q     <= lap_d;
      lap_act_q <= lap_act_d;
    end
  end

  assign shown         = lap_act_q ? lap_q : live_q;
  assign sw.lap_active = lap_act_q;
`else
  logic unused_lap;
  assign unused_lap    = sw.lap;
  assign shown         = live_q;
  assign sw.lap_active = 1'b0;
`endif

  assign sw.min_t     = shown.min_t;
  assign sw.min_o     = shown.min_o;
  assign sw.sec_t     = shown.sec_t;
  assign sw.sec_o     = shown.sec_o;
  assign sw.running   = in_run;
  assign sw.done      = (state_q == StDone);
  assign sw.blank_sec = blink_q && in_adj && !sw.adj_sel;
  assign sw.blank_min = blink_q && in_adj && sw.adj_sel;
endmodule
